grf_write_port: RTL

Register file of the pipelined MIPS datapath, and the direct consumer of the 5-bit destination-register select mux. The mux picks rt, rd or $31 for the write-back stage. This block captures the chosen address together with write data and enable, and commits the write on the clock edge. It also serves two combinational read ports to the decode stage and keeps a saturating count of committed writes for the test bench.

---
 rtl/mips_pkg.sv | 14 +
 rtl/grf_read_port.sv | 41 ++++
 rtl/grf_write_port.sv | 71 +++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types: default widths, the fixed register
// numbers the destination mux selects from, and word/address typedefs.
package mips_pkg;

    localparam int DATA_W_DFLT = 32;
    localparam int ADDR_W_DFLT = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

endpackage

// File: rtl/grf_read_port.sv
// One combinational register-file read port: register-0 masking and, when
// GRF_BYPASS_EN is defined, write-through of the in-flight write-back data.
module grf_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int NREGS  = 2 ** ADDR_W
) (
    input  logic [NREGS-1:0][DATA_W-1:0] regs_i,
    input  logic [ADDR_W-1:0]            raddr_i,
    input  logic                         wr_commit_i,
    input  logic [ADDR_W-1:0]            waddr_i,
    input  logic [DATA_W-1:0]            wdata_i,
    output logic [DATA_W-1:0]            rdata_o
);

    logic rd_zero;
    assign rd_zero = (raddr_i == ADDR_W'(REG_ZERO));

`ifdef GRF_BYPASS_EN
    logic hit;
    // wr_commit_i already excludes waddr==0 and reset, so a hit is always a real write
    assign hit = wr_commit_i && (waddr_i == raddr_i);

    always_comb begin
        rdata_o = regs_i[raddr_i];
        if (rd_zero)  rdata_o = '0;
        else if (hit) rdata_o = wdata_i;
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{wr_commit_i, waddr_i, wdata_i};

    always_comb begin
        rdata_o = regs_i[raddr_i];
        if (rd_zero) rdata_o = '0;
    end
`endif

endmodule

// File: rtl/grf_write_port.sv
// MIPS general register file: 2**ADDR_W x DATA_W storage, one write port, two
// combinational read ports, saturating committed-write counter. Macro: GRF_BYPASS_EN.
module grf_write_port
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         wr_commit;

    // Gating with reset also keeps the bypass path quiet while reset is held
    assign wr_commit = we && (waddr != ADDR_W'(REG_ZERO)) && !reset;

    always_comb begin
        regs_d = regs_q;
        if (wr_commit) regs_d[waddr] = wdata;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (wr_commit && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

    assign wr_count = cnt_q;

    grf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_rd1 (
        .regs_i      (regs_q),
        .raddr_i     (raddr1),
        .wr_commit_i (wr_commit),
        .waddr_i     (waddr),
        .wdata_i     (wdata),
        .rdata_o     (rdata1)
    );

    grf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_rd2 (
        .regs_i      (regs_q),
        .raddr_i     (raddr2),
        .wr_commit_i (wr_commit),
        .waddr_i     (waddr),
        .wdata_i     (wdata),
        .rdata_o     (rdata2)
    );

endmodule
